beta_fetch_stage: RTL and testbench
===================================

# beta_fetch_stage

Instruction fetch stage for the Bourbon 3-stage pipeline. Consumes the pipeline control unit's fetch-enable and control-hazard flags, produces the fetch-busy status, and drives a req/gnt/rvalid instruction-memory port. Owns the program counter, applies redirects from the execution stage, and presents each fetched instruction with its PC to the if-to-dec pipe register.

## Interface
- DataWidth, 32: instruction, address and PC width.
- BootAddr, 32'h0000_0000: PC value after reset; bits [1:0] are forced to 0.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rstn_i  in  1  reset; one clock; reset is asynchronous and active-low.
- pcu_ifs_fetch_en_i  in  1  fetch permission from the pipeline control unit.
- pcu_ctrl_hazard_flag_i  in  2  bit0=1: control transfer (branch/jump/trap) in execute.
- pcu_ifs_busy_o  out  1  fetch in progress (state != IDLE).
- ifs_redirect_i  in  1  execute resolved a taken branch/jump/trap.
- ifs_redirect_addr_i  in  DataWidth  redirect target.
- imem_req_o  out  1  memory request.
- imem_addr_o  out  DataWidth  request address (= PC).
- imem_gnt_i  in  1  request accepted.
- imem_rvalid_i  in  1  response data valid.
- imem_rdata_i  in  DataWidth  response instruction.
- ifs_instr_o  out  DataWidth  last delivered instruction (held).
- ifs_pc_o  out  DataWidth  PC of ifs_instr_o (held).
- ifs_valid_o  out  1  one-cycle pulse: new instruction delivered.

## Operation
- FSM states: IDLE, REQ, WAIT. Registers: pc, discard flag, ifs_instr, ifs_pc, ifs_valid.
- IDLE: if ifs_redirect_i → pc <= {addr[31:2],2'b00}, stay IDLE (redirect wins over fetch_en same cycle). Else if pcu_ifs_fetch_en_i & ~pcu_ctrl_hazard_flag_i[0] → REQ. Else stay.
- REQ: imem_req_o=1, imem_addr_o=pc; req held until imem_gnt_i (no withdrawal). gnt → WAIT.
- WAIT: on imem_rvalid_i → IDLE; if discard=0 and no redirect this cycle: ifs_instr<=rdata, ifs_pc<=pc, ifs_valid<=1, pc<=pc+4. If discard=1 or redirect this cycle: response dropped, ifs_valid stays 0, discard<=0.
- Redirect in REQ/WAIT: pc <= aligned target immediately, discard<=1; in-flight transaction still completes on bus, then dropped; next fetch uses new pc.
- Redirect in WAIT coincident with rvalid: response dropped, pc <= target, discard stays 0.
- imem_rvalid_i outside WAIT and imem_gnt_i outside REQ ignored.
- pc+4 wraps modulo 2^DataWidth (0xFFFF_FFFC → 0x0000_0000).
- pcu_ctrl_hazard_flag_i[1] unused by this block.

## Timing
- Reset (async, immediate): state IDLE, pc=BootAddr, discard=0, imem_req_o=0, imem_addr_o=BootAddr, pcu_ifs_busy_o=0, ifs_instr_o=32'h0000_0013 (NOP), ifs_pc_o=0, ifs_valid_o=0. Reset mid-transaction abandons it; no response later accepted without a new REQ.
- imem_req_o, imem_addr_o, pcu_ifs_busy_o are combinational from state/pc; ifs_* registered.
- Minimum latency: fetch_en sampled cycle N → req_o high N+1 → gnt at N+1 → WAIT N+2 → rvalid at N+2 → ifs_valid_o high N+3, busy low N+3.
- Each extra gnt/rvalid wait cycle adds one cycle; busy stays high throughout.
- ifs_valid_o is high exactly one cycle per accepted response; ifs_instr_o/ifs_pc_o hold until next delivery.
- Back-to-back: with fetch_en held high, next REQ starts cycle after return to IDLE (one fetch per ≥3 cycles).

## Test plan
- Reset then fetch_en=1, gnt and rvalid immediate, rdata=0x00A00093 → req_o at cycle 1 with addr 0x0, valid pulse at cycle 3 with instr 0x00A00093, pc_o 0x0; next req addr 0x4.
- Gnt delayed 2 cycles, rvalid delayed 3 cycles → req held steady with stable addr, busy high throughout, single valid pulse, pc advances by 4 only once.
- Redirect to 0x0000_0102 while in WAIT → returned data not delivered (no valid pulse), next request addr 0x0000_0100.
- Redirect coincident with rvalid, and redirect coincident with fetch_en in IDLE → no delivery; next request to target; no request launched in the redirect cycle.
- pcu_ctrl_hazard_flag_i=2'b01 with fetch_en=1 for 5 cycles → req_o stays 0; flag drops → req issued next cycle.
- BootAddr=0xFFFF_FFFC, one fetch completed → next req addr 0x0000_0000; assert rstn_i low during WAIT → outputs at reset values immediately, later rvalid ignored.

Source files
------------

// File: rtl/beta_fetch_stage.sv
// ---------------------------------------------------------------------------
// beta_fetch_stage : Bourbon instruction fetch (PC, req/gnt/rvalid port, if-to-dec register)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module beta_fetch_stage #(
  parameter int unsigned          DataWidth = 32,
  parameter logic [DataWidth-1:0] BootAddr  = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 pcu_ifs_fetch_en_i,
  input  logic [1:0]           pcu_ctrl_hazard_flag_i,
  output logic                 pcu_ifs_busy_o,
  input  logic                 ifs_redirect_i,
  input  logic [DataWidth-1:0] ifs_redirect_addr_i,
  output logic                 imem_req_o,
  output logic [DataWidth-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DataWidth-1:0] imem_rdata_i,
  output logic [DataWidth-1:0] ifs_instr_o,
  output logic [DataWidth-1:0] ifs_pc_o,
  output logic                 ifs_valid_o
);

  localparam logic [DataWidth-1:0] BootAligned = {BootAddr[DataWidth-1:2], 2'b00};
  localparam logic [DataWidth-1:0] NopInstr    = DataWidth'(32'h0000_0013);
  localparam logic [DataWidth-1:0] PcStep      = DataWidth'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [DataWidth-1:0] pc;
  logic [DataWidth-1:0] pc_next;
  logic                 discard;
  logic                 discard_next;
  logic [DataWidth-1:0] instr_q;
  logic [DataWidth-1:0] instr_next;
  logic [DataWidth-1:0] pc_q;
  logic [DataWidth-1:0] pc_q_next;
  logic                 valid_q;
  logic                 valid_next;
  logic [DataWidth-1:0] redirect_target;
  logic                 fetch_ok;

  // Only the control-transfer bit of the hazard flags and the word part of
  // the redirect address matter here.
  logic unused_inputs;
  assign unused_inputs = ^{pcu_ctrl_hazard_flag_i[1], ifs_redirect_addr_i[1:0]};

  assign redirect_target = {ifs_redirect_addr_i[DataWidth-1:2], 2'b00};
  assign fetch_ok        = pcu_ifs_fetch_en_i & ~pcu_ctrl_hazard_flag_i[0];

  assign imem_req_o     = (state == REQ);
  assign imem_addr_o    = pc;
  assign pcu_ifs_busy_o = (state != IDLE);
  assign ifs_instr_o    = instr_q;
  assign ifs_pc_o       = pc_q;
  assign ifs_valid_o    = valid_q;

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    discard_next = discard;
    instr_next   = instr_q;
    pc_q_next    = pc_q;
    valid_next   = 1'b0;

    case (state)
      IDLE: begin
        if (ifs_redirect_i) begin
          pc_next = redirect_target;
        end else if (fetch_ok) begin
          state_next = REQ;
        end
      end

      REQ: begin
        if (imem_gnt_i) begin
          state_next = WAIT;
        end
        // The granted (or still pending) transaction belongs to the old path.
        if (ifs_redirect_i) begin
          pc_next      = redirect_target;
          discard_next = 1'b1;
        end
      end

      WAIT: begin
        if (imem_rvalid_i) begin
          state_next   = IDLE;
          discard_next = 1'b0;
          if (ifs_redirect_i) begin
            pc_next = redirect_target;
          end else if (!discard) begin
            instr_next = imem_rdata_i;
            pc_q_next  = pc;
            valid_next = 1'b1;
            pc_next    = pc + PcStep;
          end
        end else if (ifs_redirect_i) begin
          pc_next      = redirect_target;
          discard_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      pc      <= BootAligned;
      discard <= 1'b0;
      instr_q <= NopInstr;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      discard <= discard_next;
      instr_q <= instr_next;
      pc_q    <= pc_q_next;
      valid_q <= valid_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_beta_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_beta_fetch_stage : directed scoreboard bench for beta_fetch_stage
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_beta_fetch_stage;

  logic        clk;
  logic        rstn;
  logic        fetch_en;
  logic [1:0]  hazard;
  logic        busy;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [31:0] pc_o;
  logic        valid;

  logic        b_fetch_en;
  logic        b_busy;
  logic        b_req;
  logic [31:0] b_addr;
  logic        b_gnt;
  logic        b_rvalid;
  logic [31:0] b_rdata;
  logic [31:0] b_instr;
  logic [31:0] b_pc;
  logic        b_valid;

  int passed = 0;
  int total  = 0;

  logic [63:0] exp_deliv[$];
  logic [31:0] exp_req[$];

  beta_fetch_stage #(.DataWidth(32), .BootAddr(32'h0000_0000)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .pcu_ifs_fetch_en_i(fetch_en), .pcu_ctrl_hazard_flag_i(hazard),
    .pcu_ifs_busy_o(busy),
    .ifs_redirect_i(redirect), .ifs_redirect_addr_i(redirect_addr),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .ifs_instr_o(instr), .ifs_pc_o(pc_o), .ifs_valid_o(valid)
  );

  beta_fetch_stage #(.DataWidth(32), .BootAddr(32'hFFFF_FFFC)) dut_b (
    .clk_i(clk), .rstn_i(rstn),
    .pcu_ifs_fetch_en_i(b_fetch_en), .pcu_ctrl_hazard_flag_i(2'b00),
    .pcu_ifs_busy_o(b_busy),
    .ifs_redirect_i(1'b0), .ifs_redirect_addr_i(32'h0),
    .imem_req_o(b_req), .imem_addr_o(b_addr), .imem_gnt_i(b_gnt),
    .imem_rvalid_i(b_rvalid), .imem_rdata_i(b_rdata),
    .ifs_instr_o(b_instr), .ifs_pc_o(b_pc), .ifs_valid_o(b_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every delivery and every granted request is matched
  // against what the stimulus announced.
  always @(negedge clk) begin
    if (rstn) begin
      if (valid) begin
        if (exp_deliv.size() == 0) begin
          chk("unexpected_valid", {31'b0, valid}, 32'h0);
        end else begin
          logic [63:0] e;
          e = exp_deliv.pop_front();
          chk("deliv_instr", instr, e[63:32]);
          chk("deliv_pc", pc_o, e[31:0]);
        end
      end
      if (req && gnt) begin
        if (exp_req.size() == 0) begin
          chk("unexpected_grant", addr, 32'hDEAD_BEEF);
        end else begin
          logic [31:0] a;
          a = exp_req.pop_front();
          chk("req_addr", addr, a);
        end
      end
    end
  end

  // mode 0: plain fetch; 1: redirect in WAIT before rvalid; 2: redirect with rvalid
  task automatic fetch(input int gd, input int rd, input logic [31:0] data,
                       input logic [31:0] a, input int mode, input logic [31:0] raddr);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("req_high", {31'b0, req}, 32'h1);
    for (int i = 0; i < gd; i++) begin
      chk("req_held", {31'b0, req}, 32'h1);
      chk("addr_stable", addr, a);
      chk("busy_req", {31'b0, busy}, 32'h1);
      tick();
    end
    gnt = 1'b1;
    exp_req.push_back(a);
    tick();
    gnt = 1'b0;
    if (mode == 1) begin
      redirect = 1'b1;
      redirect_addr = raddr;
      tick();
      redirect = 1'b0;
    end
    for (int i = 0; i < rd; i++) begin
      chk("busy_wait", {31'b0, busy}, 32'h1);
      chk("req_low_wait", {31'b0, req}, 32'h0);
      tick();
    end
    rvalid = 1'b1;
    rdata  = data;
    if (mode == 2) begin
      redirect = 1'b1;
      redirect_addr = raddr;
    end
    if (mode == 0) exp_deliv.push_back({data, a});
    tick();
    rvalid   = 1'b0;
    redirect = 1'b0;
    chk("busy_done", {31'b0, busy}, 32'h0);
    chk("valid_pulse", {31'b0, valid}, (mode == 0) ? 32'h1 : 32'h0);
  endtask

  initial begin
    rstn = 1'b0; fetch_en = 1'b0; hazard = 2'b00; redirect = 1'b0;
    redirect_addr = 32'h0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    b_fetch_en = 1'b0; b_gnt = 1'b0; b_rvalid = 1'b0; b_rdata = 32'h0;
    #12;
    chk("rst_req", {31'b0, req}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_b_addr", b_addr, 32'hFFFF_FFFC);
    tick();
    rstn = 1'b1;
    tick();

    fetch(0, 0, 32'h00A0_0093, 32'h0, 0, 32'h0);
    chk("next_addr", addr, 32'h4);
    tick();
    chk("valid_one_cycle", {31'b0, valid}, 32'h0);
    chk("instr_held", instr, 32'h00A0_0093);

    fetch(2, 3, 32'h1111_1111, 32'h4, 0, 32'h0);
    chk("pc_once", addr, 32'h8);

    fetch(0, 1, 32'h2222_2222, 32'h8, 1, 32'h0000_0102);
    chk("redir_wait_addr", addr, 32'h100);
    chk("redir_instr_held", instr, 32'h1111_1111);
    fetch(0, 0, 32'h3333_3333, 32'h100, 0, 32'h0);

    fetch(1, 0, 32'h4444_4444, 32'h104, 2, 32'h0000_0200);
    chk("redir_rvalid_addr", addr, 32'h200);

    fetch_en = 1'b1; redirect = 1'b1; redirect_addr = 32'h0000_0301;
    tick();
    redirect = 1'b0; fetch_en = 1'b0;
    chk("idle_redir_no_req", {31'b0, req}, 32'h0);
    chk("idle_redir_addr", addr, 32'h300);
    fetch(0, 0, 32'h5555_5555, 32'h300, 0, 32'h0);

    hazard = 2'b01; fetch_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hazard_no_req", {31'b0, req}, 32'h0);
    end
    hazard = 2'b00;
    fetch(0, 0, 32'h6666_6666, 32'h304, 0, 32'h0);

    rvalid = 1'b1; rdata = 32'hBAD0_0001;
    tick();
    rvalid = 1'b0;
    chk("stray_rvalid", {31'b0, valid}, 32'h0);

    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    gnt = 1'b1;
    exp_req.push_back(32'h308);
    tick();
    gnt = 1'b0;
    chk("wait_busy", {31'b0, busy}, 32'h1);
    rstn = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_addr", addr, 32'h0);
    chk("arst_instr", instr, 32'h0000_0013);
    chk("arst_pc", pc_o, 32'h0);
    tick();
    rstn = 1'b1;
    rvalid = 1'b1; rdata = 32'hBAD0_0002;
    tick();
    rvalid = 1'b0;
    chk("post_rst_rvalid", {31'b0, valid}, 32'h0);
    chk("post_rst_busy", {31'b0, busy}, 32'h0);

    b_fetch_en = 1'b1;
    tick();
    b_fetch_en = 1'b0;
    chk("b_req", {31'b0, b_req}, 32'h1);
    chk("b_req_addr", b_addr, 32'hFFFF_FFFC);
    b_gnt = 1'b1;
    tick();
    b_gnt = 1'b0;
    b_rvalid = 1'b1; b_rdata = 32'h0000_0073;
    tick();
    b_rvalid = 1'b0;
    chk("b_valid", {31'b0, b_valid}, 32'h1);
    chk("b_instr", b_instr, 32'h0000_0073);
    chk("b_pc", b_pc, 32'hFFFF_FFFC);
    chk("b_wrap_addr", b_addr, 32'h0);

    tick();
    tick();
    chk("deliv_queue_empty", exp_deliv.size(), 32'h0);
    chk("req_queue_empty", exp_req.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
